ball_ctl: RTL and testbench

//  Pong ball engine. Advances ball position once per video frame, bounces it off the top and

---
 rtl/ball_ctl_pkg.sv | 28 ++
 rtl/ball_ctl_if.sv | 26 ++
 rtl/ball_ctl_collide.sv | 74 +++++++
 rtl/ball_ctl.sv | 137 +++++++++++++
 tb/tb_ball_ctl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/ball_ctl_pkg.sv
// Shared geometry, timing constants and FSM state type for the pong ball engine.
package ball_ctl_pkg;

    localparam int SCREEN_W    = 1024;
    localparam int SCREEN_H    = 768;
    localparam int BALL_SIZE   = 16;
    localparam int BALL_SPEED  = 4;
    localparam int PADDLE_W    = 16;
    localparam int PADDLE_H    = 96;
    localparam int LPAD_X      = 32;
    localparam int RPAD_X      = 976;
    localparam int MAX_SCORE   = 9;
    localparam int SERVE_DELAY = 60;
    localparam int CENTRE_X    = (SCREEN_W - BALL_SIZE) / 2;
    localparam int CENTRE_Y    = (SCREEN_H - BALL_SIZE) / 2;

    // Wide enough that paddle_y + PADDLE_H never wraps for any 12-bit paddle input.
    typedef logic signed [13:0] scoord_t;

    localparam scoord_t SPD = scoord_t'(BALL_SPEED);

    typedef enum logic [2:0] {IDLE, SERVE, MOVE, SCORE, OVER} state_t;

    function automatic scoord_t widen(input logic [11:0] v);
        return scoord_t'({2'b00, v});
    endfunction

endpackage

// File: rtl/ball_ctl_if.sv
// Frame/paddle inputs and draw/score outputs of the ball engine.
interface ball_ctl_if;

    logic        vblnk_in;
    logic        serve;
    logic [11:0] lpad_y;
    logic [11:0] rpad_y;
    logic [11:0] ball_x;
    logic [11:0] ball_y;
    logic        ball_vis;
    logic [3:0]  score_l;
    logic [3:0]  score_r;
    logic        game_over;
    logic        hit_pulse;

    modport master (
        output vblnk_in, serve, lpad_y, rpad_y,
        input  ball_x, ball_y, ball_vis, score_l, score_r, game_over, hit_pulse
    );

    modport slave (
        input  vblnk_in, serve, lpad_y, rpad_y,
        output ball_x, ball_y, ball_vis, score_l, score_r, game_over, hit_pulse
    );

endinterface

// File: rtl/ball_ctl_collide.sv
// Combinational next-position step: wall bounce, paddle reflection and miss detection.
module ball_collide
    import ball_ctl_pkg::*;
(
    input  logic [11:0] x,
    input  logic [11:0] y,
    input  scoord_t     vx,
    input  scoord_t     vy,
    input  logic [11:0] lpad_y,
    input  logic [11:0] rpad_y,
    output logic [11:0] nx,
    output logic [11:0] ny,
    output scoord_t     nvx,
    output scoord_t     nvy,
    output logic        hit,
    output logic        miss_l,
    output logic        miss_r
);

    localparam scoord_t ZERO   = '0;
    localparam scoord_t Y_MAX  = scoord_t'(SCREEN_H - BALL_SIZE);
    localparam scoord_t X_MAX  = scoord_t'(SCREEN_W - BALL_SIZE);
    localparam scoord_t L_FACE = scoord_t'(LPAD_X + PADDLE_W);
    localparam scoord_t R_FACE = scoord_t'(RPAD_X);
    localparam scoord_t BALL   = scoord_t'(BALL_SIZE);
    localparam scoord_t PAD_H  = scoord_t'(PADDLE_H);
    localparam scoord_t R_STOP = scoord_t'(RPAD_X - BALL_SIZE);

    scoord_t cx, cy, tx, ty, lp, rp;
    logic    l_ovl, r_ovl, l_hit, r_hit;

    always_comb begin
        cx    = widen(x);
        cy    = widen(y);
        tx    = cx + vx;
        ty    = cy + vy;
        lp    = widen(lpad_y);
        rp    = widen(rpad_y);
        l_ovl = (ty + BALL > lp) && (ty < lp + PAD_H);
        r_ovl = (ty + BALL > rp) && (ty < rp + PAD_H);
        l_hit = (vx < ZERO) && (tx <= L_FACE) && (cx >= L_FACE) && l_ovl;
        r_hit = (vx > ZERO) && (tx + BALL >= R_FACE) && (cx + BALL <= R_FACE) && r_ovl;

        nvx    = vx;
        nvy    = vy;
        nx     = tx[11:0];
        ny     = ty[11:0];
        hit    = l_hit | r_hit;
        miss_l = 1'b0;
        miss_r = 1'b0;

        // Vertical and horizontal are independent so a corner reflects on both axes.
        if (ty <= ZERO) begin
            ny  = '0;
            nvy = SPD;
        end else if (ty >= Y_MAX) begin
            ny  = Y_MAX[11:0];
            nvy = -SPD;
        end

        if (l_hit) begin
            nx  = L_FACE[11:0];
            nvx = SPD;
        end else if (r_hit) begin
            nx  = R_STOP[11:0];
            nvx = -SPD;
        end else if (tx <= ZERO) begin
            miss_l = 1'b1;
        end else if (tx >= X_MAX) begin
            miss_r = 1'b1;
        end
    end

endmodule

// File: rtl/ball_ctl.sv
// Pong ball engine: frame-tick driven serve/move/score FSM holding ball position and scores.
module ball_ctl
    import ball_ctl_pkg::*;
(
    input  logic      pclk,
    input  logic      rst,
    ball_ctl_if.slave bus
);

    localparam logic [11:0] CX       = 12'(CENTRE_X);
    localparam logic [11:0] CY       = 12'(CENTRE_Y);
    localparam logic [5:0]  LAST     = 6'(SERVE_DELAY - 1);
    localparam logic [3:0]  WIN_PREV = 4'(MAX_SCORE - 1);

    state_t      state;
    logic [5:0]  cnt;
    logic [11:0] x, y;
    scoord_t     vx, vy;
    logic        vis, go, hit_q, vblnk_d, serve_d;
    logic [3:0]  sl, sr;

    logic [11:0] nx, ny;
    scoord_t     nvx, nvy;
    logic        hit, miss_l, miss_r;
    logic        tick, serve_edge;

    assign tick       = bus.vblnk_in & ~vblnk_d;
    assign serve_edge = bus.serve & ~serve_d;

    ball_collide u_collide (
        .x      (x),
        .y      (y),
        .vx     (vx),
        .vy     (vy),
        .lpad_y (bus.lpad_y),
        .rpad_y (bus.rpad_y),
        .nx     (nx),
        .ny     (ny),
        .nvx    (nvx),
        .nvy    (nvy),
        .hit    (hit),
        .miss_l (miss_l),
        .miss_r (miss_r)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            x       <= CX;
            y       <= CY;
            vx      <= SPD;
            vy      <= SPD;
            vis     <= 1'b1;
            sl      <= '0;
            sr      <= '0;
            go      <= 1'b0;
            hit_q   <= 1'b0;
            vblnk_d <= 1'b1;
            serve_d <= 1'b1;
        end else begin
            vblnk_d <= bus.vblnk_in;
            serve_d <= bus.serve;
            hit_q   <= 1'b0;
            unique case (state)
                IDLE: if (serve_edge) begin
                    state <= SERVE;
                    cnt   <= '0;
                end
                SERVE: if (tick) begin
                    if (cnt == LAST) begin
                        state <= MOVE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                MOVE: if (tick) begin
                    if (miss_l || miss_r) begin
                        // Next serve heads toward whoever conceded.
                        x   <= CX;
                        y   <= CY;
                        vx  <= miss_l ? -SPD : SPD;
                        vy  <= SPD;
                        vis <= 1'b0;
                        cnt <= '0;
                        if (miss_l) sr <= sr + 4'd1;
                        else        sl <= sl + 4'd1;
                        if ((miss_l && sr == WIN_PREV) || (miss_r && sl == WIN_PREV)) begin
                            state <= OVER;
                            go    <= 1'b1;
                        end else begin
                            state <= SCORE;
                        end
                    end else begin
                        x     <= nx;
                        y     <= ny;
                        vx    <= nvx;
                        vy    <= nvy;
                        hit_q <= hit;
                    end
                end
                SCORE: if (tick) begin
                    if (cnt == LAST) begin
                        state <= SERVE;
                        vis   <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                OVER: if (serve_edge) begin
                    state <= IDLE;
                    sl    <= '0;
                    sr    <= '0;
                    go    <= 1'b0;
                    vis   <= 1'b1;
                    x     <= CX;
                    y     <= CY;
                    vx    <= SPD;
                    vy    <= SPD;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ball_x    = x;
    assign bus.ball_y    = y;
    assign bus.ball_vis  = vis;
    assign bus.score_l   = sl;
    assign bus.score_r   = sr;
    assign bus.game_over = go;
    assign bus.hit_pulse = hit_q;

endmodule

// File: tb/tb_ball_ctl.sv
// Bench for ball_ctl: hand-computed vector table, reset corner, then a random game vs a frame-level model.
module tb_ball_ctl;

    logic pclk;
    logic rst;
    ball_ctl_if bus();

    ball_ctl dut (.pclk(pclk), .rst(rst), .bus(bus));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input int ex, input int ey, input int evis,
                             input int esl, input int esr, input int ego);
        chk({tag, ".x"},     int'(bus.ball_x),    ex);
        chk({tag, ".y"},     int'(bus.ball_y),    ey);
        chk({tag, ".vis"},   int'(bus.ball_vis),  evis);
        chk({tag, ".sl"},    int'(bus.score_l),   esl);
        chk({tag, ".sr"},    int'(bus.score_r),   esr);
        chk({tag, ".over"},  int'(bus.game_over), ego);
    endtask

    // One video frame: tick on the first edge, hit_pulse sampled one and two cycles later.
    task automatic frame(output int h1, output int h2);
        @(negedge pclk); bus.vblnk_in = 1'b1;
        @(negedge pclk); h1 = int'(bus.hit_pulse);
        @(negedge pclk); h2 = int'(bus.hit_pulse); bus.vblnk_in = 1'b0;
        @(negedge pclk);
    endtask

    task automatic pulse_serve();
        @(negedge pclk); bus.serve = 1'b1;
        @(negedge pclk); bus.serve = 1'b0;
    endtask

    // Frame-level game model, phases and rules written straight from the game description.
    localparam int WAITING = 0, SERVING = 1, PLAYING = 2, POINT = 3, WON = 4;
    int m_phase, m_x, m_y, m_vx, m_vy, m_sl, m_sr, m_wait, m_hit;
    int cur_lp, cur_rp;

    task automatic m_reset();
        m_phase = WAITING; m_x = 504; m_y = 376; m_vx = 4; m_vy = 4;
        m_sl = 0; m_sr = 0; m_wait = 0; m_hit = 0;
    endtask

    task automatic m_serve();
        if (m_phase == WAITING) begin m_phase = SERVING; m_wait = 0; end
        else if (m_phase == WON) m_reset();
    endtask

    task automatic m_point(input int left_missed);
        m_x = 504; m_y = 376; m_vy = 4; m_wait = 0;
        if (left_missed != 0) begin m_sr++; m_vx = -4; end
        else begin m_sl++; m_vx = 4; end
        m_phase = (m_sl == 9 || m_sr == 9) ? WON : POINT;
    endtask

    task automatic m_tick();
        int nx, ny, lh, rh;
        m_hit = 0;
        case (m_phase)
            SERVING: begin m_wait++; if (m_wait == 60) m_phase = PLAYING; end
            POINT: begin
                m_wait++;
                if (m_wait == 60) begin m_phase = SERVING; m_wait = 0; end
            end
            PLAYING: begin
                nx = m_x + m_vx;
                ny = m_y + m_vy;
                lh = int'(m_vx < 0 && nx <= 48 && m_x >= 48 && ny + 16 > cur_lp && ny < cur_lp + 96);
                rh = int'(m_vx > 0 && nx + 16 >= 976 && m_x + 16 <= 976 && ny + 16 > cur_rp && ny < cur_rp + 96);
                if (ny <= 0) begin m_y = 0; m_vy = 4; end
                else if (ny >= 752) begin m_y = 752; m_vy = -4; end
                else m_y = ny;
                if (lh != 0) begin m_x = 48; m_vx = 4; m_hit = 1; end
                else if (rh != 0) begin m_x = 960; m_vx = -4; m_hit = 1; end
                else if (nx <= 0) m_point(1);
                else if (nx >= 1008) m_point(0);
                else m_x = nx;
            end
            default: ;
        endcase
    endtask

    function automatic int clamp_pad(input int v);
        if (v < 0) return 0;
        if (v > 672) return 672;
        return v;
    endfunction

    typedef struct {
        int ticks; int serve; int lpad; int rpad;
        int x; int y; int vis; int sl; int sr; int go; int hit;
    } vec_t;
    vec_t vec [18];

    initial begin
        int h1, h2, frames, hits;
        vec[0]  = '{0,   0, 0, 0,   504, 376, 1, 0, 0, 0, 0};
        vec[1]  = '{3,   0, 0, 0,   504, 376, 1, 0, 0, 0, 0};
        vec[2]  = '{59,  1, 0, 0,   504, 376, 1, 0, 0, 0, 0};
        vec[3]  = '{1,   0, 0, 0,   504, 376, 1, 0, 0, 0, 0};
        vec[4]  = '{1,   0, 0, 0,   508, 380, 1, 0, 0, 0, 0};
        vec[5]  = '{93,  0, 0, 0,   880, 752, 1, 0, 0, 0, 0};
        vec[6]  = '{1,   1, 0, 0,   884, 748, 1, 0, 0, 0, 0};
        vec[7]  = '{18,  0, 0, 640, 956, 676, 1, 0, 0, 0, 0};
        vec[8]  = '{1,   0, 0, 640, 960, 672, 1, 0, 0, 0, 1};
        vec[9]  = '{1,   0, 0, 0,   956, 668, 1, 0, 0, 0, 0};
        vec[10] = '{166, 0, 0, 0,   292, 4,   1, 0, 0, 0, 0};
        vec[11] = '{1,   0, 0, 0,   288, 0,   1, 0, 0, 0, 0};
        vec[12] = '{71,  0, 0, 0,   4,   284, 1, 0, 0, 0, 0};
        vec[13] = '{1,   0, 0, 0,   504, 376, 0, 0, 1, 0, 0};
        vec[14] = '{59,  1, 0, 0,   504, 376, 0, 0, 1, 0, 0};
        vec[15] = '{1,   0, 0, 0,   504, 376, 1, 0, 1, 0, 0};
        vec[16] = '{60,  0, 0, 0,   504, 376, 1, 0, 1, 0, 0};
        vec[17] = '{1,   0, 0, 0,   500, 380, 1, 0, 1, 0, 0};

        rst = 1'b1; bus.vblnk_in = 1'b0; bus.serve = 1'b0; bus.lpad_y = '0; bus.rpad_y = '0;
        repeat (3) @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);
        chk("reset.hit", int'(bus.hit_pulse), 0);

        for (int unsigned i = 0; i < 18; i++) begin
            bus.lpad_y = 12'(vec[i].lpad);
            bus.rpad_y = 12'(vec[i].rpad);
            if (vec[i].serve != 0) pulse_serve();
            h1 = 0; h2 = 0;
            for (int t = 0; t < vec[i].ticks; t++) frame(h1, h2);
            if (vec[i].ticks > 0) begin
                chk($sformatf("vec%0d.hit", i), h1, vec[i].hit);
                chk($sformatf("vec%0d.hit_len", i), h2, 0);
            end
            check_out($sformatf("vec%0d", i), vec[i].x, vec[i].y, vec[i].vis,
                      vec[i].sl, vec[i].sr, vec[i].go);
        end

        // Reset mid-MOVE with vblank held high across release.
        repeat (5) frame(h1, h2);
        @(negedge pclk); bus.vblnk_in = 1'b1; rst = 1'b1;
        @(negedge pclk); rst = 1'b0;
        @(negedge pclk);
        check_out("midrst", 504, 376, 1, 0, 0, 0);
        chk("midrst.hit", int'(bus.hit_pulse), 0);
        @(negedge pclk); bus.vblnk_in = 1'b0;
        @(negedge pclk);

        // Random game against the model until someone wins.
        m_reset();
        pulse_serve(); m_serve();
        frames = 0; hits = 0;
        while (m_phase != WON && frames < 15000) begin
            if ($urandom_range(0, 9) < 3) cur_lp = clamp_pad(m_y - 40 + int'($urandom_range(0, 40)));
            else cur_lp = int'($urandom_range(0, 672));
            if ($urandom_range(0, 9) < 3) cur_rp = clamp_pad(m_y - 40 + int'($urandom_range(0, 40)));
            else cur_rp = int'($urandom_range(0, 672));
            bus.lpad_y = 12'(cur_lp);
            bus.rpad_y = 12'(cur_rp);
            if ($urandom_range(0, 19) == 0) begin pulse_serve(); m_serve(); end
            frame(h1, h2);
            m_tick();
            hits += m_hit;
            chk("rnd.hit", h1, m_hit);
            chk("rnd.hit_len", h2, 0);
            check_out("rnd", m_x, m_y, int'(m_phase != POINT && m_phase != WON),
                      m_sl, m_sr, int'(m_phase == WON));
            frames++;
        end
        chk("rnd.game_over_reached", int'(bus.game_over), 1);

        pulse_serve(); m_serve();
        @(negedge pclk);
        check_out("restart", m_x, m_y, 1, m_sl, m_sr, 0);
        repeat (3) frame(h1, h2);
        check_out("restart.idle", 504, 376, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
